// File: rtl/tmp_sd_pkg.sv
// tmp_sd_pkg: shared state encoding, default timing and helpers for the temperature front-end controller
package tmp_sd_pkg;

   typedef enum logic [3:0] {
      IDLE, PRECHARGE, BLANK_D, DIODE, TAIL_D, BLANK_B, BIG, TAIL_B, OUTPUT
   } state_t;

   localparam int T_PRE_DEF   = 4;
   localparam int T_DIODE_DEF = 2;
   localparam int T_BIG_DEF   = 4;
   localparam int N_CYC_DEF   = 8;

   function automatic int max3(input int a, input int b, input int c);
      return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
   endfunction

endpackage

// File: rtl/tmp_phase_timer.sv
// tmp_phase_timer: loadable down-counter flagging the last cycle of a timed phase
module tmp_phase_timer #(
   parameter int MAX_LEN = 4,
   localparam int CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
   localparam int LW = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [LW-1:0] len,
   output logic          done
);

   logic [CW-1:0] cnt;

   // load len-1 on phase entry, then count down and rest at zero
   always_ff @(posedge clk)
      if (reset) cnt <= '0;
      else if (load) cnt <= CW'(len - LW'(1));
      else if (cnt != '0) cnt <= cnt - CW'(1);

   assign done = cnt == '0;

endmodule

// File: rtl/tmp_sd_ctrl.sv
// tmp_sd_ctrl: switch sequencer and charge-balance accumulator for the temperature front end (option TMP_CHOP_EN)
module tmp_sd_ctrl import tmp_sd_pkg::*; #(
   parameter int T_PRE   = T_PRE_DEF,
   parameter int T_DIODE = T_DIODE_DEF,
   parameter int T_BIG   = T_BIG_DEF,
   parameter int N_CYC   = N_CYC_DEF,
   localparam int RES_W  = $clog2(N_CYC + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             cmp,
   output logic             preChrg,
   output logic             PII1,
   output logic             PII2,
   output logic             PI1,
   output logic             PI2,
   output logic             PA,
   output logic             PB,
   output logic             PC,
   output logic             PD,
   output logic             src_n,
   output logic             snk,
   output logic             busy,
   output logic             valid,
   output logic [RES_W-1:0] result
);

   localparam int MAX_LEN = max3(T_PRE, T_DIODE, T_BIG);
   localparam int LW      = $clog2(MAX_LEN + 1);

   state_t           state, nxt;
   logic [RES_W-1:0] acc, cyc;
   logic [LW-1:0]    len;
   logic             chop, chop_n, samp, samp_n, enter_big, load, done, last, act;

   assign last      = cyc == RES_W'(N_CYC - 1);
   assign enter_big = (nxt == BIG) && (state != BIG);
   assign load      = (nxt != state) && (nxt inside {PRECHARGE, DIODE, BIG});
   assign len       = (nxt == PRECHARGE) ? LW'(T_PRE) : (nxt == DIODE) ? LW'(T_DIODE) : LW'(T_BIG);
   assign samp_n    = enter_big ? cmp : samp;
   assign act       = nxt inside {BLANK_D, DIODE, TAIL_D, BLANK_B, BIG, TAIL_B};
`ifdef TMP_CHOP_EN
   assign chop_n    = (nxt == PRECHARGE) ? 1'b0 : (state == TAIL_B) ? ~chop : chop;
`else
   assign chop_n    = 1'b0;
`endif

   tmp_phase_timer #(.MAX_LEN(MAX_LEN)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .len   (len),
      .done  (done)
   );

   // phase sequencing; timed phases leave on the timer's last cycle
   always_comb begin
      nxt = state;
      case (state)
         IDLE:      nxt = en ? PRECHARGE : IDLE;
         PRECHARGE: nxt = done ? BLANK_D : PRECHARGE;
         BLANK_D:   nxt = DIODE;
         DIODE:     nxt = done ? TAIL_D : DIODE;
         TAIL_D:    nxt = BLANK_B;
         BLANK_B:   nxt = BIG;
         BIG:       nxt = done ? TAIL_B : BIG;
         TAIL_B:    nxt = last ? OUTPUT : BLANK_D;
         OUTPUT:    nxt = en ? PRECHARGE : IDLE;
         default:   nxt = IDLE;
      endcase
   end

   // state, accumulator and outputs registered from the next state so switches change glitch-free
   always_ff @(posedge clk)
      if (reset) begin
         state   <= IDLE;
         acc     <= '0;
         cyc     <= '0;
         chop    <= 1'b0;
         samp    <= 1'b0;
         preChrg <= 1'b0;
         PII1    <= 1'b0;
         PII2    <= 1'b0;
         PI1     <= 1'b0;
         PI2     <= 1'b0;
         PA      <= 1'b0;
         PB      <= 1'b0;
         PC      <= 1'b0;
         PD      <= 1'b0;
         src_n   <= 1'b1;
         snk     <= 1'b0;
         busy    <= 1'b0;
         valid   <= 1'b0;
         result  <= '0;
      end else begin
         state   <= nxt;
         chop    <= chop_n;
         samp    <= samp_n;
         acc     <= (nxt == PRECHARGE) ? '0 : enter_big ? acc + RES_W'(cmp ^ chop) : acc;
         cyc     <= (nxt == PRECHARGE) ? '0 : (state == TAIL_B && nxt == BLANK_D) ? cyc + RES_W'(1) : cyc;
         preChrg <= nxt == PRECHARGE;
         PII1    <= nxt inside {BLANK_D, DIODE, TAIL_D};
         PII2    <= nxt == DIODE;
         PI1     <= nxt inside {BLANK_B, BIG, TAIL_B};
         PI2     <= nxt == BIG;
         PA      <= act && !chop_n;
         PD      <= act && !chop_n;
         PB      <= act && chop_n;
         PC      <= act && chop_n;
         src_n   <= !((nxt == BIG) && !samp_n);
         snk     <= (nxt == BIG) && samp_n;
         busy    <= nxt != IDLE;
         valid   <= nxt == OUTPUT;
         result  <= (nxt == OUTPUT) ? acc : result;
      end

endmodule
